// File: rtl/core_inst_seq.sv
// Instruction sequencer for one core tile: weight fetch, kernel load, activation
// fetch and execute, then OFIFO-to-PMEM writeback, driving the registered 40-bit bus.
module core_inst_seq #(
  parameter int col       = 8,
  parameter int row       = 8,
  parameter int KLOAD_CYC = 16,
  parameter int DRAIN_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  w_base,
  input  logic [7:0]  x_base,
  input  logic [8:0]  p_base,
  input  logic [7:0]  nij,
  input  logic        mode,
  input  logic        l0_ready,
  input  logic        ofifo_valid,
  output logic [39:0] inst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [39:0] IDLE_W = 40'h30_0403_0000;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_WF   = 4'd1;
  localparam logic [3:0] S_KL   = 4'd2;
  localparam logic [3:0] S_KG   = 4'd3;
  localparam logic [3:0] S_XF   = 4'd4;
  localparam logic [3:0] S_EX   = 4'd5;
  localparam logic [3:0] S_DR   = 4'd6;
  localparam logic [3:0] S_WB   = 4'd7;
  localparam logic [3:0] S_DN   = 4'd8;

  // The kernel needs at least col+row shift cycles to reach every PE.
  localparam int          KCYC       = (KLOAD_CYC < col + row) ? col + row : KLOAD_CYC;
  localparam logic [8:0]  COL_N      = 9'(col);
  localparam logic [15:0] KCYC_LAST  = 16'(KCYC - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);

  logic [3:0]  state, state_nxt;
  logic [39:0] inst_nxt;
  logic        busy_nxt, done_nxt, err_nxt;
  logic [8:0]  iss_cnt, iss_nxt, wr_cnt, wr_nxt;
  logic        pend, pend_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        latch;

  logic [7:0]  w_base_l, x_base_l, nij_l;
  logic [8:0]  p_base_l;
  logic        mode_l;

  logic [8:0]  fetch_n;
  logic [7:0]  fetch_base;
  logic [15:0] nij_last;

  assign fetch_n    = (state == S_WF) ? COL_N : {1'b0, nij_l};
  assign fetch_base = (state == S_WF) ? w_base_l : x_base_l;
  assign nij_last   = 16'(nij_l) - 16'd1;

  always_comb begin
    state_nxt = state;
    inst_nxt  = IDLE_W;
    iss_nxt   = iss_cnt;
    wr_nxt    = wr_cnt;
    pend_nxt  = 1'b0;
    cnt_nxt   = cnt;
    err_nxt   = err;
    done_nxt  = 1'b0;
    latch     = 1'b0;
    if (state != S_IDLE) inst_nxt[2] = mode_l;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch     = 1'b1;
          state_nxt = S_WF;
          iss_nxt   = '0;
          wr_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      S_WF, S_XF: begin
        // Read issued now lands in L0 one cycle later (SRAM read latency).
        if (l0_ready && iss_cnt < fetch_n) begin
          inst_nxt[17]   = 1'b0;
          inst_nxt[15:8] = fetch_base + iss_cnt[7:0];
          iss_nxt        = iss_cnt + 9'd1;
          pend_nxt       = 1'b1;
        end
        if (pend) begin
          inst_nxt[3] = 1'b1;
          wr_nxt      = wr_cnt + 9'd1;
          if (wr_cnt == fetch_n - 9'd1) begin
            state_nxt = (state == S_WF) ? S_KL : S_EX;
            iss_nxt   = '0;
            wr_nxt    = '0;
            cnt_nxt   = '0;
          end
        end
      end
      S_KL: begin
        inst_nxt[0] = 1'b1;
        inst_nxt[4] = 1'b1;
        cnt_nxt     = cnt + 16'd1;
        if (cnt == KCYC_LAST) begin
          state_nxt = S_KG;
          cnt_nxt   = '0;
        end
      end
      S_KG: state_nxt = S_XF;
      S_EX: begin
        inst_nxt[1] = 1'b1;
        inst_nxt[4] = 1'b1;
        cnt_nxt     = cnt + 16'd1;
        if (cnt == nij_last) begin
          state_nxt = S_DR;
          cnt_nxt   = '0;
        end
      end
      S_DR: begin
        if (ofifo_valid) begin
          state_nxt = S_WB;
          cnt_nxt   = '0;
        end else if (cnt == DRAIN_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_DN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_WB: begin
        if (ofifo_valid && iss_cnt < {1'b0, nij_l}) begin
          inst_nxt[7] = 1'b1;
          iss_nxt     = iss_cnt + 9'd1;
          pend_nxt    = 1'b1;
        end
        // OFIFO data popped last cycle is written to PMEM now.
        if (pend) begin
          inst_nxt[37]    = 1'b0;
          inst_nxt[36]    = 1'b0;
          inst_nxt[35:27] = p_base_l + wr_cnt;
          wr_nxt          = wr_cnt + 9'd1;
          if (wr_cnt == {1'b0, nij_l} - 9'd1) begin
            state_nxt = S_DN;
            iss_nxt   = '0;
            wr_nxt    = '0;
          end
        end
      end
      S_DN: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      inst     <= IDLE_W;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      iss_cnt  <= '0;
      wr_cnt   <= '0;
      pend     <= 1'b0;
      cnt      <= '0;
      w_base_l <= '0;
      x_base_l <= '0;
      p_base_l <= '0;
      nij_l    <= 8'd1;
      mode_l   <= 1'b0;
    end else begin
      state   <= state_nxt;
      inst    <= inst_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      iss_cnt <= iss_nxt;
      wr_cnt  <= wr_nxt;
      pend    <= pend_nxt;
      cnt     <= cnt_nxt;
      if (latch) begin
        w_base_l <= w_base;
        x_base_l <= x_base;
        p_base_l <= p_base;
        nij_l    <= (nij == 8'd0) ? 8'd1 : nij;
        mode_l   <= mode;
      end
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Randomized scoreboard bench for core_inst_seq: expected addresses and run lengths
// are queued at start; a negedge monitor checks every bus word against them.
module tb_core_inst_seq;
  localparam int COL  = 8;
  localparam int KCYC = 16;
  localparam int DMAX = 64;
  localparam logic [39:0] IDLE_W = 40'h30_0403_0000;

  logic        clk = 1'b0;
  logic        reset, start, mode, l0_ready, ofifo_valid;
  logic [7:0]  w_base, x_base, nij;
  logic [8:0]  p_base;
  logic [39:0] inst;
  logic        busy, done, err;

  core_inst_seq dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
    .p_base(p_base), .nij(nij), .mode(mode), .l0_ready(l0_ready),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_a0[$];
  logic [8:0] q_pa[$];
  int         q_exec[$];
  logic       q_err[$];
  logic       cur_mode = 1'b0;
  int         l0_pct = 100;
  int         ofv_pct = 100;
  logic       stall_arm = 1'b0;
  int         rd_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Input driver: random back-pressure plus an optional one-shot 3-cycle L0 stall.
  initial begin
    int   stall_left;
    logic fired;
    stall_left  = 0;
    fired       = 1'b0;
    l0_ready    = 1'b1;
    ofifo_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_arm) fired = 1'b0;
      if (stall_left > 0) begin
        l0_ready = 1'b0;
        stall_left--;
      end else if (stall_arm && !fired && rd_seen == COL + 2) begin
        l0_ready   = 1'b0;
        stall_left = 2;
        fired      = 1'b1;
      end else begin
        l0_ready = ($urandom_range(99) < l0_pct);
      end
      ofifo_valid = ($urandom_range(99) < ofv_pct);
    end
  end

  // Monitor: inputs seen at one negedge are the ones the DUT decides on at the
  // next posedge, so they pair with the bus word seen at the following negedge.
  initial begin
    logic prev_rd, prev_ofrd, prev_ofv, prev_l0r, prev_err, prev_load;
    int   load_run, exec_run, last_exec, cyc, exp_n;
    logic active;
    prev_rd = 0; prev_ofrd = 0; prev_ofv = 0; prev_l0r = 0; prev_err = 0;
    load_run = 0; exec_run = 0; last_exec = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_rd = 0; prev_ofrd = 0; prev_ofv = 0; prev_l0r = 0; prev_err = 0;
        load_run = 0; exec_run = 0; rd_seen = 0;
        q_a0.delete(); q_pa.delete(); q_exec.delete(); q_err.delete();
        continue;
      end
      chk("const_fields", 64'({inst[39:38], inst[26], inst[25:18], inst[6:5]}),
          64'({2'b00, 1'b1, 8'h00, 2'b00}));
      active = !inst[17] | inst[3] | inst[4] | inst[1] | inst[0] | inst[7] | !inst[37];
      if (active) begin
        chk("mode_bit", 64'(inst[2]), 64'(cur_mode));
        chk("busy_active", 64'(busy), 64'(1));
      end
      if (!inst[17]) begin
        chk("xmem_wen0", 64'(inst[16]), 64'(1));
        chk("rd_needs_ready", 64'(prev_l0r), 64'(1));
        chk("a0_expected", 64'(q_a0.size() != 0), 64'(1));
        if (q_a0.size() != 0) chk("a0_addr", 64'(inst[15:8]), 64'(q_a0.pop_front()));
        rd_seen++;
      end
      if (inst[3] | prev_rd) chk("l0_wr_lag", 64'(inst[3]), 64'(prev_rd));
      if (inst[7]) chk("ofrd_needs_valid", 64'(prev_ofv), 64'(1));
      if (!inst[37] | prev_ofrd) chk("pmem_lag", 64'(!inst[37]), 64'(prev_ofrd));
      if (!inst[37]) begin
        chk("pmem_wen", 64'(inst[36]), 64'(0));
        chk("pa_expected", 64'(q_pa.size() != 0), 64'(1));
        if (q_pa.size() != 0) chk("pmem_addr", 64'(inst[35:27]), 64'(q_pa.pop_front()));
      end
      prev_load = (load_run != 0);
      if (inst[0]) begin
        chk("load_l0_rd", 64'(inst[4]), 64'(1));
        load_run++;
      end else if (prev_load) begin
        chk("load_len", 64'(load_run), 64'(KCYC));
        load_run = 0;
      end
      if (inst[1]) begin
        chk("exec_l0_rd", 64'(inst[4]), 64'(1));
        exec_run++;
        last_exec = cyc;
      end else if (exec_run != 0) begin
        exp_n = (q_exec.size() != 0) ? q_exec.pop_front() : -1;
        chk("exec_len", 64'(exec_run), 64'(exp_n));
        exec_run = 0;
      end
      if (err && !prev_err) chk("drain_timeout", 64'(cyc - last_exec), 64'(DMAX));
      if (done) begin
        chk("done_busy_low", 64'(busy), 64'(0));
        chk("done_tile_expected", 64'(q_err.size() != 0), 64'(1));
        if (q_err.size() != 0) chk("done_err", 64'(err), 64'(q_err.pop_front()));
        chk("done_queues_empty", 64'(q_a0.size() + q_pa.size() + q_exec.size()), 64'(0));
        rd_seen = 0;
      end
      prev_rd   = !inst[17];
      prev_ofrd = inst[7];
      prev_ofv  = ofifo_valid;
      prev_l0r  = l0_ready;
      prev_err  = err;
    end
  end

  task automatic push_tile(input logic [7:0] wb, input logic [7:0] xb, input logic [8:0] pb,
                           input logic [7:0] n_in, input logic m, input logic exp_err);
    int n;
    n = (n_in == 0) ? 1 : int'(n_in);
    for (int i = 0; i < COL; i++) q_a0.push_back(8'(wb + 8'(i)));
    for (int i = 0; i < n; i++) q_a0.push_back(8'(xb + 8'(i)));
    if (!exp_err) for (int i = 0; i < n; i++) q_pa.push_back(9'(pb + 9'(i)));
    q_exec.push_back(n);
    q_err.push_back(exp_err);
    cur_mode = m;
  endtask

  task automatic pulse_start(input logic [7:0] wb, input logic [7:0] xb, input logic [8:0] pb,
                             input logic [7:0] n_in, input logic m);
    @(posedge clk); #1;
    w_base = wb; x_base = xb; p_base = pb; nij = n_in; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w_base = 8'($urandom); x_base = 8'($urandom); p_base = 9'($urandom);
    nij = 8'($urandom); mode = ~m;
  endtask

  task automatic run_tile(input logic [7:0] wb, input logic [7:0] xb, input logic [8:0] pb,
                          input logic [7:0] n_in, input logic m, input logic exp_err);
    int t;
    push_tile(wb, xb, pb, n_in, m, exp_err);
    pulse_start(wb, xb, pb, n_in, m);
    repeat (9) @(posedge clk);
    // Start while busy must be ignored and must not re-latch config.
    pulse_start(8'($urandom), 8'($urandom), 9'($urandom), 8'($urandom), ~m);
    t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done), 64'(1));
    repeat (3) @(negedge clk);
    chk("idle_after_tile", 64'(inst), 64'(IDLE_W));
    chk("busy_after_tile", 64'(busy), 64'(0));
  endtask

  initial begin
    int t;
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; nij = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_inst", 64'(inst), 64'(IDLE_W));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));

    l0_pct = 100; ofv_pct = 100;
    run_tile(8'h00, 8'hFC, 9'h1F0, 8'd6, 1'b1, 1'b0);
    stall_arm = 1'b1; ofv_pct = 60;
    run_tile(8'h10, 8'hFC, 9'h1FE, 8'd4, 1'b0, 1'b0);
    stall_arm = 1'b0;
    l0_pct = 70;
    run_tile(8'hF9, 8'h80, 9'h1FF, 8'd255, 1'b1, 1'b0);
    run_tile(8'h22, 8'h33, 9'h044, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      l0_pct  = $urandom_range(40, 100);
      ofv_pct = $urandom_range(30, 100);
      run_tile(8'($urandom), 8'($urandom), 9'($urandom),
               ($urandom_range(9) == 0) ? 8'd0 : 8'($urandom_range(1, 24)),
               1'($urandom), 1'b0);
    end

    l0_pct = 100; ofv_pct = 0;
    run_tile(8'h05, 8'h06, 9'h007, 8'd3, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("err_sticky", 64'(err), 64'(1));
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'(0));
    chk("rst2_inst", 64'(inst), 64'(IDLE_W));

    // Reset in the middle of EXEC abandons the tile.
    ofv_pct = 100;
    push_tile(8'h40, 8'h50, 9'h060, 8'd20, 1'b1, 1'b0);
    pulse_start(8'h40, 8'h50, 9'h060, 8'd20, 1'b1);
    t = 0;
    while (!inst[1] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("exec_reached", 64'(inst[1]), 64'(1));
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_inst", 64'(inst), 64'(IDLE_W));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 64'(inst), 64'(IDLE_W));
    chk("post_rst_busy", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
